seq_scan_ctrl: RTL

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/seq_scan_ctrl.sv
// Scan controller: serialises one word LSB-first into a sequence detector,
// drains it for N cycles and counts the detector's valid cycles.
module seq_scan_ctrl #(
   parameter int N  = 3,
   parameter int W  = 8,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic [W-1:0]  word,
   input  logic [N-1:0]  pattern,
   input  logic          valid,
   output logic          a,
   output logic [N-1:0]  seq,
   output logic          det_reset_n,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] match_count
);

   localparam int MAXL = (W > N) ? W : N;
   localparam int IW   = (MAXL > 2) ? $clog2(MAXL) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_SHIFT = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [IW-1:0] r_bit_idx;
   logic [IW-1:0] w_idx_nxt;
   logic [W-1:0]  r_word;
   logic [W-1:0]  w_word_nxt;
   logic [N-1:0]  r_pat;
   logic [N-1:0]  w_pat_nxt;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic [CW-1:0] w_count_inc;
   logic          r_a;
   logic          w_a_nxt;
   logic          r_busy;
   logic          r_done;

   // Next-state, index, latch and saturating-count logic
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_bit_idx;
      w_word_nxt  = r_word;
      w_pat_nxt   = r_pat;
      w_count_nxt = r_count;
      if (r_count == {CW{1'b1}}) begin
         w_count_inc = r_count;
      end else begin
         w_count_inc = r_count + CW'(1);
      end
      case (r_state)
         S_IDLE: begin
            // abort takes priority over a simultaneous start
            if (start && !abort) begin
               w_state_nxt = S_CLEAR;
               w_word_nxt  = word;
               w_pat_nxt   = pattern;
               w_count_nxt = {CW{1'b0}};
               w_idx_nxt   = {IW{1'b0}};
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CLEAR: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = {CW{1'b0}};
            end else begin
               w_state_nxt = S_SHIFT;
               w_idx_nxt   = {IW{1'b0}};
            end
         end
         S_SHIFT: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = {CW{1'b0}};
               w_idx_nxt   = {IW{1'b0}};
            end else begin
               if (valid) begin
                  w_count_nxt = w_count_inc;
               end else begin
                  w_count_nxt = r_count;
               end
               if (r_bit_idx == IW'(W - 1)) begin
                  w_state_nxt = S_FLUSH;
                  w_idx_nxt   = {IW{1'b0}};
               end else begin
                  w_idx_nxt   = r_bit_idx + IW'(1);
               end
            end
         end
         S_FLUSH: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = {CW{1'b0}};
               w_idx_nxt   = {IW{1'b0}};
            end else begin
               if (valid) begin
                  w_count_nxt = w_count_inc;
               end else begin
                  w_count_nxt = r_count;
               end
               if (r_bit_idx == IW'(N - 1)) begin
                  w_state_nxt = S_DONE;
                  w_idx_nxt   = {IW{1'b0}};
               end else begin
                  w_idx_nxt   = r_bit_idx + IW'(1);
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = {IW{1'b0}};
         end
      endcase
   end

   // Serial bit for the coming cycle, taken from the already-latched word
   always_comb begin
      if (w_state_nxt == S_SHIFT) begin
         w_a_nxt = r_word[w_idx_nxt];
      end else begin
         w_a_nxt = 1'b0;
      end
   end

   // State and registered-output update
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_bit_idx <= {IW{1'b0}};
         r_word    <= {W{1'b0}};
         r_pat     <= {N{1'b0}};
         r_count   <= {CW{1'b0}};
         r_a       <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_idx <= w_idx_nxt;
         r_word    <= w_word_nxt;
         r_pat     <= w_pat_nxt;
         r_count   <= w_count_nxt;
         r_a       <= w_a_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
         r_done    <= (w_state_nxt == S_DONE);
      end
   end

   // Detector reset must track reset_n asynchronously, so it is decoded here
   assign det_reset_n = reset_n & (r_state != S_CLEAR);
   assign a           = r_a;
   assign seq         = r_pat;
   assign busy        = r_busy;
   assign done        = r_done;
   assign match_count = r_count;

endmodule
